// File: rtl/mrd_fsm_ctrl.sv
// Frame sequencer for the mixed-radix DFT memory engine.
// Walks a frame through sink, one read/write-back pass per radix stage,
// and source, with a per-pass watchdog and one-cycle error pulses.
module mrd_fsm_ctrl #(
   parameter int WAIT_RD = 2,
   parameter int TIMEOUT = 4095
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sink_valid,
   input  logic       sink_sop,
   input  logic       sink_eop,
   input  logic [2:0] num_of_factors,
   input  logic       rd_end,
   input  logic       wr_end,
   input  logic       source_end,
   output logic [2:0] fsm,
   output logic [2:0] fsm_r,
   output logic [2:0] cnt_stage,
   output logic [2:0] nf_lat,
   output logic       sink_ready,
   output logic       busy,
   output logic       err_cfg,
   output logic       err_sop,
   output logic       err_timeout
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] TO_V   = WD_W'(TIMEOUT);
   localparam logic [3:0]      WAIT_V = 4'(WAIT_RD);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SINK    = 3'd1,
      ST_WAIT_RD = 3'd2,
      ST_RD      = 3'd3,
      ST_WAIT_WR = 3'd4,
      ST_SOURCE  = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      state_r_q;
   logic [2:0]      cnt_q, cnt_d;
   logic [2:0]      nf_q, nf_d;
   logic [3:0]      wait_q, wait_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            sticky_q, sticky_d;
   logic            sink_rdy_q, busy_q;
   logic            err_cfg_q, err_cfg_d;
   logic            err_sop_q, err_sop_d;
   logic            err_to_q, err_to_d;

   logic            sop_hit, eop_hit, nf_legal;
   logic [2:0]      nf_m1;
   logic [WD_W-1:0] wd_inc;

   assign sop_hit  = sink_valid & sink_sop;
   assign eop_hit  = sink_valid & sink_eop;
   assign nf_legal = (num_of_factors != 3'd0) && (num_of_factors != 3'd7);
   assign nf_m1    = nf_q - 3'd1;
   assign wd_inc   = wd_q + 1'b1;

   // Next-state and next-value decode for the frame sequencer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      nf_d      = nf_q;
      wait_d    = wait_q;
      wd_d      = wd_q;
      sticky_d  = sticky_q;
      err_cfg_d = 1'b0;
      err_sop_d = 1'b0;
      err_to_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sop_hit) begin
               if (nf_legal) begin
                  nf_d  = num_of_factors;
                  cnt_d = 3'd0;
                  if (eop_hit) begin
                     // Single-beat frame skips the sink phase entirely.
                     state_d = ST_WAIT_RD;
                     wait_d  = 4'd1;
                  end else begin
                     state_d = ST_SINK;
                  end
               end else begin
                  err_cfg_d = 1'b1;
               end
            end
         end
         ST_SINK: begin
            if (eop_hit) begin
               state_d = ST_WAIT_RD;
               wait_d  = 4'd1;
            end else if (sop_hit) begin
               // A fresh SOP restarts the frame with a re-checked stage count.
               if (nf_legal) begin
                  err_sop_d = 1'b1;
                  nf_d      = num_of_factors;
                  cnt_d     = 3'd0;
               end else begin
                  err_cfg_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_WAIT_RD: begin
            if (wait_q == WAIT_V) begin
               state_d = ST_RD;
               wd_d    = '0;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         ST_RD: begin
            wd_d = wd_inc;
            if (wd_inc == TO_V) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
               cnt_d    = 3'd0;
               sticky_d = 1'b0;
               wd_d     = '0;
            end else begin
               // Writes trail reads, so an early wr_end is remembered.
               if (wr_end) sticky_d = 1'b1;
               if (rd_end) state_d = ST_WAIT_WR;
            end
         end
         ST_WAIT_WR: begin
            wd_d = wd_inc;
            if (wd_inc == TO_V) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
               cnt_d    = 3'd0;
               sticky_d = 1'b0;
               wd_d     = '0;
            end else if (wr_end || sticky_q) begin
               sticky_d = 1'b0;
               if (cnt_q == nf_m1) begin
                  state_d = ST_SOURCE;
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  state_d = ST_RD;
                  wd_d    = '0;
               end
            end
         end
         ST_SOURCE: begin
            if (source_end) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         state_r_q  <= 3'd0;
         cnt_q      <= 3'd0;
         nf_q       <= 3'd0;
         wait_q     <= 4'd0;
         wd_q       <= '0;
         sticky_q   <= 1'b0;
         sink_rdy_q <= 1'b1;
         busy_q     <= 1'b0;
         err_cfg_q  <= 1'b0;
         err_sop_q  <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         state_r_q  <= state_q;
         cnt_q      <= cnt_d;
         nf_q       <= nf_d;
         wait_q     <= wait_d;
         wd_q       <= wd_d;
         sticky_q   <= sticky_d;
         sink_rdy_q <= (state_d == ST_IDLE) || (state_d == ST_SINK);
         busy_q     <= (state_d != ST_IDLE);
         err_cfg_q  <= err_cfg_d;
         err_sop_q  <= err_sop_d;
         err_to_q   <= err_to_d;
      end
   end

   assign fsm         = state_q;
   assign fsm_r       = state_r_q;
   assign cnt_stage   = cnt_q;
   assign nf_lat      = nf_q;
   assign sink_ready  = sink_rdy_q;
   assign busy        = busy_q;
   assign err_cfg     = err_cfg_q;
   assign err_sop     = err_sop_q;
   assign err_timeout = err_to_q;

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Bench for mrd_fsm_ctrl: directed frames plus random traffic, all
// outputs compared every cycle against a behavioural frame model.
module tb_mrd_fsm_ctrl;
   localparam int WAIT_RD = 2;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sink_valid, sink_sop, sink_eop;
   logic [2:0] num_of_factors;
   logic       rd_end, wr_end, source_end;
   logic [2:0] fsm, fsm_r, cnt_stage, nf_lat;
   logic       sink_ready, busy, err_cfg, err_sop, err_timeout;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: phase numbers are the published fsm codes.
   int m_ph, m_ph_prev, m_stage, m_nf, m_wait, m_dog;
   bit m_early_wr, m_ecfg, m_esop, m_eto;

   mrd_fsm_ctrl #(.WAIT_RD(WAIT_RD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
      .num_of_factors(num_of_factors),
      .rd_end(rd_end), .wr_end(wr_end), .source_end(source_end),
      .fsm(fsm), .fsm_r(fsm_r), .cnt_stage(cnt_stage), .nf_lat(nf_lat),
      .sink_ready(sink_ready), .busy(busy),
      .err_cfg(err_cfg), .err_sop(err_sop), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_ph_prev = 0; m_stage = 0; m_nf = 0; m_wait = 0; m_dog = 0;
      m_early_wr = 0; m_ecfg = 0; m_esop = 0; m_eto = 0;
   endtask

   task automatic abort_pass(inout int nxt);
      m_eto = 1; nxt = 0; m_stage = 0; m_early_wr = 0; m_dog = 0;
   endtask

   // One clock of the frame rules, using the inputs present at the edge.
   task automatic model_step();
      int  nxt;
      bit  sop, eop, legal;
      nxt    = m_ph;
      m_ecfg = 0; m_esop = 0; m_eto = 0;
      sop    = sink_valid && sink_sop;
      eop    = sink_valid && sink_eop;
      legal  = (num_of_factors >= 1) && (num_of_factors <= 6);
      if (m_ph == 0) begin
         if (sop && legal) begin
            m_nf = num_of_factors; m_stage = 0;
            nxt = eop ? 2 : 1;
            m_wait = 1;
         end else if (sop) m_ecfg = 1;
      end else if (m_ph == 1) begin
         if (eop) begin
            nxt = 2; m_wait = 1;
         end else if (sop && legal) begin
            m_esop = 1; m_nf = num_of_factors; m_stage = 0;
         end else if (sop) begin
            m_ecfg = 1; nxt = 0;
         end
      end else if (m_ph == 2) begin
         if (m_wait == WAIT_RD) begin
            nxt = 3; m_dog = 0;
         end else m_wait++;
      end else if (m_ph == 3 || m_ph == 4) begin
         m_dog++;
         if (m_dog == TIMEOUT) abort_pass(nxt);
         else if (m_ph == 3) begin
            if (wr_end) m_early_wr = 1;
            if (rd_end) nxt = 4;
         end else if (wr_end || m_early_wr) begin
            m_early_wr = 0;
            if (m_stage == m_nf - 1) nxt = 5;
            else begin
               m_stage++; nxt = 3; m_dog = 0;
            end
         end
      end else if (m_ph == 5) begin
         if (source_end) nxt = 0;
      end
      m_ph_prev = m_ph;
      m_ph      = nxt;
   endtask

   task automatic check_all();
      chk("fsm", fsm, m_ph);
      chk("fsm_r", fsm_r, m_ph_prev);
      chk("cnt_stage", cnt_stage, m_stage);
      chk("nf_lat", nf_lat, m_nf);
      chk("sink_ready", sink_ready, (m_ph <= 1));
      chk("busy", busy, (m_ph != 0));
      chk("err_cfg", err_cfg, m_ecfg);
      chk("err_sop", err_sop, m_esop);
      chk("err_timeout", err_timeout, m_eto);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      #1;
      check_all();
   endtask

   task automatic idle_in();
      sink_valid = 0; sink_sop = 0; sink_eop = 0; num_of_factors = 3'd0;
      rd_end = 0; wr_end = 0; source_end = 0;
   endtask

   task automatic wait_fsm(input int target, input int budget);
      int k = 0;
      while (fsm !== 3'(target) && k < budget) begin
         cyc(); k++;
      end
      chk($sformatf("reach_fsm%0d", target), fsm, target);
   endtask

   task automatic start_frame(input int nf, input bit with_eop);
      idle_in();
      sink_valid = 1; sink_sop = 1; sink_eop = with_eop; num_of_factors = 3'(nf);
      cyc();
      idle_in();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      model_reset();
      repeat (2) cyc();
      chk("rst_fsm", fsm, 0);
      chk("rst_sink_ready", sink_ready, 1);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // Normal frame, three stages.
      start_frame(3, 0);
      chk("n3_sink", fsm, 1);
      chk("n3_nf", nf_lat, 3);
      sink_valid = 1;
      repeat (11) cyc();
      sink_eop = 1;
      cyc();
      idle_in();
      chk("n3_wait1", fsm, 2);
      cyc();
      chk("n3_wait2", fsm, 2);
      cyc();
      chk("n3_rd", fsm, 3);
      chk("n3_rd_fsm_r", fsm_r, 2);
      for (int s = 0; s < 3; s++) begin
         chk("n3_stage", cnt_stage, s);
         rd_end = 1; cyc(); idle_in();
         chk("n3_wwe", fsm, 4);
         wr_end = 1; cyc(); idle_in();
         if (s < 2) begin
            chk("n3_back_rd", fsm, 3);
            chk("n3_strobe", fsm_r, 4);
         end
      end
      chk("n3_source", fsm, 5);
      chk("n3_last_stage", cnt_stage, 2);
      source_end = 1; cyc(); idle_in();
      chk("n3_idle", fsm, 0);
      chk("n3_hold_stage", cnt_stage, 2);
      chk("n3_busy", busy, 0);

      // Single-beat frame, one stage.
      start_frame(1, 1);
      chk("n1_direct_wait", fsm, 2);
      chk("n1_stage0", cnt_stage, 0);
      wait_fsm(3, 8);
      rd_end = 1; cyc(); idle_in();
      wr_end = 1; cyc(); idle_in();
      chk("n1_source", fsm, 5);
      chk("n1_stage", cnt_stage, 0);
      source_end = 1; cyc(); idle_in();

      // Illegal stage counts.
      start_frame(0, 0);
      chk("nf0_err", err_cfg, 1);
      chk("nf0_fsm", fsm, 0);
      chk("nf0_ready", sink_ready, 1);
      cyc();
      chk("nf0_pulse_end", err_cfg, 0);
      start_frame(7, 0);
      chk("nf7_err", err_cfg, 1);
      chk("nf7_fsm", fsm, 0);
      cyc();

      // SOP inside sink restarts the frame.
      start_frame(2, 0);
      sink_valid = 1; sink_sop = 1; num_of_factors = 3'd4;
      cyc(); idle_in();
      chk("resop_err", err_sop, 1);
      chk("resop_nf", nf_lat, 4);
      chk("resop_fsm", fsm, 1);
      sink_valid = 1; sink_sop = 1; num_of_factors = 3'd0;
      cyc(); idle_in();
      chk("resop_bad_cfg", err_cfg, 1);
      chk("resop_bad_fsm", fsm, 0);

      // Early wr_end held across the Rd phase.
      start_frame(2, 1);
      wait_fsm(3, 8);
      wr_end = 1; cyc(); idle_in();
      chk("sticky_stay_rd", fsm, 3);
      rd_end = 1; cyc(); idle_in();
      chk("sticky_wwe", fsm, 4);
      cyc();
      chk("sticky_back_rd", fsm, 3);
      chk("sticky_stage", cnt_stage, 1);
      rd_end = 1; cyc(); idle_in();
      wr_end = 1; cyc(); idle_in();
      chk("sticky_source", fsm, 5);
      source_end = 1; cyc(); idle_in();

      // Watchdog with no rd_end.
      start_frame(1, 1);
      wait_fsm(3, 8);
      for (int i = 1; i <= TIMEOUT; i++) begin
         cyc();
         if (i < TIMEOUT) chk("wd_quiet", err_timeout, 0);
      end
      chk("wd_pulse", err_timeout, 1);
      chk("wd_fsm", fsm, 0);
      chk("wd_stage", cnt_stage, 0);
      cyc();

      // Asynchronous reset in the middle of the last stage.
      start_frame(3, 1);
      wait_fsm(3, 8);
      for (int s = 0; s < 2; s++) begin
         rd_end = 1; cyc(); idle_in();
         wr_end = 1; cyc(); idle_in();
      end
      rd_end = 1; cyc(); idle_in();
      chk("mid_fsm", fsm, 4);
      chk("mid_stage", cnt_stage, 2);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_fsm", fsm, 0);
      chk("arst_fsm_r", fsm_r, 0);
      chk("arst_stage", cnt_stage, 0);
      chk("arst_nf", nf_lat, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", sink_ready, 1);
      model_reset();
      cyc();
      @(negedge clk);
      rst_n = 1'b1;
      start_frame(2, 1);
      chk("post_rst_fsm", fsm, 2);
      chk("post_rst_nf", nf_lat, 2);

      // Random traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         sink_valid     = ($urandom % 2) == 0;
         sink_sop       = ($urandom % 8) == 0;
         sink_eop       = ($urandom % 6) == 0;
         num_of_factors = 3'($urandom % 8);
         rd_end         = ($urandom % 4) == 0;
         wr_end         = ($urandom % 4) == 0;
         source_end     = ($urandom % 5) == 0;
         cyc();
      end
      idle_in();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mrd_fsm_ctrl.md
Name: mrd_fsm_ctrl

Overview:
Top-level sequencer for the mixed-radix DFT memory engine. It accepts a frame on the sink side and steps through the frame states (Idle, Sink, Wait_to_rd, Rd, Wait_wr_end, Source). It drives fsm, fsm_r and cnt_stage to the read, write-back and source blocks. It advances one radix stage per read/write-back pass until all NumOfFactors stages are done, with a watchdog on each pass.

Parameters:
WAIT_RD, 2, cycles spent in Wait_to_rd before entering Rd (1..15)
TIMEOUT, 4095, maximum cycles allowed in one Rd + Wait_wr_end pass before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sink_valid  in  1  input sample valid
sink_sop  in  1  first sample of frame (qualified by sink_valid)
sink_eop  in  1  last sample of frame (qualified by sink_valid)
num_of_factors  in  3  number of radix stages for the frame, legal 1..6, sampled at SOP
rd_end  in  1  one-cycle pulse from read block: last read of the stage issued
wr_end  in  1  one-cycle pulse from write-back block: last write of the stage done
source_end  in  1  one-cycle pulse: last output sample sent
fsm  out  3  current state: Idle=0, Sink=1, Wait_to_rd=2, Rd=3, Wait_wr_end=4, Source=5
fsm_r  out  3  fsm delayed one cycle
cnt_stage  out  3  current stage index 0..nf-1
nf_lat  out  3  latched num_of_factors
sink_ready  out  1  high in Idle and Sink
busy  out  1  high whenever fsm != Idle
err_cfg  out  1  one-cycle pulse: illegal num_of_factors at SOP
err_sop  out  1  one-cycle pulse: SOP received in Sink
err_timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (async assert, sync release): fsm=fsm_r=Idle, cnt_stage=0, nf_lat=0, wait and watchdog counters=0. All error pulses=0. All outputs are registered.
- Idle: on sink_valid&sink_sop:
  - If num_of_factors in 1..6: latch nf_lat, cnt_stage<=0, go to Sink.
  - Otherwise: pulse err_cfg and stay in Idle.
  - If sop and eop arrive in the same beat with a legal nf: go directly to Wait_to_rd.
- Sink:
  - sink_valid&sink_eop -> Wait_to_rd.
  - sink_valid&sink_sop without eop: pulse err_sop, relatch nf_lat (same legality check), stay in Sink so the frame restarts. If the new nf is illegal, pulse err_cfg instead and go to Idle.
- Wait_to_rd: a counter loads 1 on entry. On the cycle the count equals WAIT_RD, go to Rd, so exactly WAIT_RD cycles are spent here.
- Rd: on rd_end go to Wait_wr_end. Writes are pipelined behind reads, so a wr_end seen in Rd is held in a sticky flag. A held wr_end counts as received on the first Wait_wr_end cycle.
- Wait_wr_end: on wr_end (or the sticky flag), clear the flag, then:
  - If cnt_stage == nf_lat-1: go to Source.
  - Otherwise: cnt_stage<=cnt_stage+1 and go to Rd.
  - fsm_r therefore differs from fsm for exactly one cycle at each Rd entry; downstream blocks use this as the stage-start strobe.
- Source: on source_end go to Idle. cnt_stage stays at nf_lat-1 until the next SOP, which resets it to 0.
- Watchdog:
  - Cleared on every Rd entry; counts every cycle in Rd or Wait_wr_end.
  - When it reaches TIMEOUT: pulse err_timeout, go to Idle, clear cnt_stage and the sticky flag.
- Pulses in wrong states: rd_end, wr_end (except the Rd sticky case) and source_end outside their consuming state are ignored. Sink inputs outside Idle/Sink are ignored.
- Width rules: cnt_stage never exceeds 5. nf_lat-1 is computed in 3 bits, and nf_lat is never 0 outside Idle.

Test Plan:
- Normal frame, nf=3, WAIT_RD=2: SOP, 11 samples, EOP, then rd_end/wr_end pairs per stage, then source_end -> fsm sequence 0,1,2,2,3,4,3,4,3,4,5,0; cnt_stage 0,1,2; fsm_r lags fsm by one cycle; busy low only in Idle.
- nf=1 with single-beat SOP+EOP -> Idle to Wait_to_rd directly; after one Rd/Wait_wr_end pass go to Source; cnt_stage stays 0.
- num_of_factors=0 and then 7 at SOP -> err_cfg pulses once each, fsm stays 0, sink_ready stays 1.
- wr_end asserted one cycle before rd_end during Rd (nf=2) -> sticky flag set; cnt_stage goes to 1 and fsm returns to 3 one cycle after entering 4.
- TIMEOUT=16, no rd_end after Rd entry -> err_timeout pulses 16 cycles after Rd entry; fsm=0, cnt_stage=0.
- rst_n asserted mid-stage (fsm=4, cnt_stage=2) -> all outputs reset immediately without waiting for a clk edge; next SOP starts a clean frame.
